// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared constants, pattern enum and colour-bar table for the raster generator
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned CNT_LIMIT    = 4096;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'b00,
        PAT_CHECKER  = 2'b01,
        PAT_GRADIENT = 2'b10,
        PAT_SOLID    = 2'b11
    } pattern_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        rgb = RGB_BLACK;
        case (idx)
            3'd0: rgb = RGB_WHITE;
            3'd1: rgb = RGB_YELLOW;
            3'd2: rgb = RGB_CYAN;
            3'd3: rgb = RGB_GREEN;
            3'd4: rgb = RGB_MAGENTA;
            3'd5: rgb = RGB_RED;
            3'd6: rgb = RGB_BLUE;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// rtl/video_timing_if.sv - control inputs and raster/pixel outputs of the timing generator
interface video_timing_if;
    logic        en;
    logic [1:0]  pattern_sel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;

    modport master (
        input  en, pattern_sel,
        output de, hsync, vsync, red, green, blue, x, y, frame_start
    );

    modport slave (
        output en, pattern_sel,
        input  de, hsync, vsync, red, green, blue, x, y, frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - combinational test-pattern source mapping (pattern, x, y) to RGB
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
    input  pattern_e    i_pat,
    input  logic [11:0] i_x,
    input  logic [7:0]  i_y,
    output logic [23:0] o_rgb
);

    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [11:0] w_bar_idx;
    logic [2:0]  w_bar;

    // Columns past the eighth full bar (division remainder) stay in the last bar.
    assign w_bar_idx = i_x / BAR_W;
    assign w_bar     = (w_bar_idx > 12'd7) ? 3'd7 : w_bar_idx[2:0];

    always_comb begin
        o_rgb = RGB_BLACK;
        case (i_pat)
            PAT_BARS:     o_rgb = bar_rgb(w_bar);
            PAT_CHECKER:  o_rgb = (i_x[5] ^ i_y[5]) ? RGB_WHITE : RGB_BLACK;
            PAT_GRADIENT: o_rgb = {i_x[7:0], i_y, i_x[7:0] ^ i_y};
            PAT_SOLID:    o_rgb = RGB_WHITE;
            default:      o_rgb = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster counters with registered sync, data-enable, colour and coordinates
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic           pix_clk,
    input  logic           rst_n,
    video_timing_if.master vif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT || H_ACTIVE < 8) begin : g_bad_timing
            $error("video_timing_gen: totals must fit 12-bit counters and H_ACTIVE must be >= 8");
        end
    endgenerate

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT13  = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT13  = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] r_h_cnt, r_v_cnt;
    pattern_e    r_pat;
    logic        r_de, r_hsync, r_vsync, r_frame_start;
    logic [23:0] r_rgb;
    logic [11:0] r_x, r_y;

    logic [12:0] w_h, w_v;
    logic        w_h_wrap, w_v_wrap, w_origin, w_active, w_hs_on, w_vs_on;
    pattern_e    w_pat;
    logic [23:0] w_rgb;

    assign w_h      = {1'b0, r_h_cnt};
    assign w_v      = {1'b0, r_v_cnt};
    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_origin = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_active = (w_h < H_ACT13) && (w_v < V_ACT13);
    assign w_hs_on  = (w_h >= HS_START) && (w_h < HS_END);
    assign w_vs_on  = (w_v >= VS_START) && (w_v < VS_END);

    // The origin pixel already uses the freshly sampled selection, so a new pattern starts exactly at frame start.
    assign w_pat = w_origin ? pattern_e'(vif.pattern_sel) : r_pat;

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .i_pat (w_pat),
        .i_x   (r_h_cnt),
        .i_y   (r_v_cnt[7:0]),
        .o_rgb (w_rgb)
    );

    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_pat         <= PAT_BARS;
            r_de          <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_rgb         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else if (vif.en) begin
            r_h_cnt <= w_h_wrap ? 12'd0 : r_h_cnt + 12'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
            end
            if (w_origin) begin
                r_pat <= w_pat;
            end
            r_de          <= w_active;
            r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
            r_rgb         <= w_active ? w_rgb : 24'd0;
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_frame_start <= w_origin;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign vif.de          = r_de;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.red         = r_rgb[23:16];
    assign vif.green       = r_rgb[15:8];
    assign vif.blue        = r_rgb[7:0];
    assign vif.x           = r_x;
    assign vif.y           = r_y;
    assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HA = 260, HF = 4, HS = 8, HB = 8;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic        de, hs, vs, fs;
        logic [23:0] rgb;
        logic [11:0] x, y;
        logic [1:0]  pat;
    } exp_t;

    logic pix_clk = 1'b0;
    logic rst_n   = 1'b0;
    video_timing_if vif();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .pix_clk (pix_clk),
        .rst_n   (rst_n),
        .vif     (vif)
    );

    always #5 pix_clk = ~pix_clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fs_times[$];
    exp_t exp_q[$];
    int   pos  = 0;
    int   mpat = 0;
    int   mh, mv;
    exp_t cur, mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int pat, input int x, input int y);
        int bar;
        case (pat)
            0: begin
                bar = x / (HA / 8);
                if (bar > 7) bar = 7;
                return BARS[bar];
            end
            1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            2: return {8'(x % 256), 8'(y % 256), 8'((x % 256) ^ (y % 256))};
            default: return 24'hFFFFFF;
        endcase
    endfunction

    always @(posedge pix_clk) cyc <= cyc + 1;

    // Reference: one linear position within the frame; h/v derived arithmetically.
    always @(posedge pix_clk) begin
        if (!rst_n) begin
            pos  = 0;
            mpat = 0;
            cur  = '{de: 1'b0, hs: ~HPOL, vs: ~VPOL, fs: 1'b0, rgb: 24'd0, x: 12'd0, y: 12'd0, pat: 2'd0};
        end else if (!vif.en) begin
            cur.fs = 1'b0;
        end else begin
            mh = pos % HT;
            mv = pos / HT;
            if (pos == 0) mpat = int'(vif.pattern_sel);
            cur.de  = (mh < HA) && (mv < VA);
            cur.hs  = (mh >= HA + HF && mh < HA + HF + HS) ? HPOL : ~HPOL;
            cur.vs  = (mv >= VA + VF && mv < VA + VF + VS) ? VPOL : ~VPOL;
            cur.rgb = cur.de ? ref_rgb(mpat, mh, mv) : 24'd0;
            cur.x   = 12'(mh);
            cur.y   = 12'(mv);
            cur.fs  = (pos == 0);
            cur.pat = 2'(mpat);
            pos = (pos + 1) % FRAME;
        end
        exp_q.push_back(cur);
    end

    always @(negedge pix_clk) begin
        if (vif.frame_start === 1'b1) fs_times.push_back(cyc);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ctl_de_hs_vs_fs", {60'd0, vif.de, vif.hsync, vif.vsync, vif.frame_start},
                  {60'd0, mon_e.de, mon_e.hs, mon_e.vs, mon_e.fs});
            check("rgb", {40'd0, vif.red, vif.green, vif.blue}, {40'd0, mon_e.rgb});
            if (mon_e.de) begin
                check("xy", {40'd0, vif.x, vif.y}, {40'd0, mon_e.x, mon_e.y});
                if (mon_e.pat == 2'd0 && mon_e.x == 12'd0)
                    check("bar_first_col", {40'd0, vif.red, vif.green, vif.blue}, 64'hFFFFFF);
                if (mon_e.pat == 2'd0 && mon_e.x == 12'd32)
                    check("bar_yellow", {40'd0, vif.red, vif.green, vif.blue}, 64'hFFFF00);
                if (mon_e.pat == 2'd0 && mon_e.x == 12'd259)
                    check("bar_remainder_col", {40'd0, vif.red, vif.green, vif.blue}, 64'h000000);
                if (mon_e.pat == 2'd2 && mon_e.x == 12'd255 && mon_e.y == 12'd3)
                    check("gradient_255_3", {40'd0, vif.red, vif.green, vif.blue}, 64'hFF03FC);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge pix_clk);
        #1;
    endtask

    int rel_edge, n0, r, guard;

    initial begin
        vif.en = 1'b0;
        vif.pattern_sel = 2'b00;
        rst_n = 1'b0;
        step(3);
        check("rst_de", {63'd0, vif.de}, 64'd0);
        check("rst_hsync", {63'd0, vif.hsync}, {63'd0, ~HPOL});
        check("rst_vsync", {63'd0, vif.vsync}, {63'd0, ~VPOL});

        rst_n = 1'b1;
        vif.en = 1'b1;
        rel_edge = cyc;
        step(FRAME + 3 * HT + 17);
        vif.pattern_sel = 2'b10;
        step(2 * FRAME);
        if (fs_times.size() >= 3) begin
            check("first_frame_start", 64'(fs_times[0]), 64'(rel_edge + 1));
            check("frame_period_a", 64'(fs_times[1] - fs_times[0]), 64'(FRAME));
            check("frame_period_b", 64'(fs_times[2] - fs_times[1]), 64'(FRAME));
        end else begin
            check("frame_start_count", 64'(fs_times.size()), 64'd3);
        end

        guard = 0;
        while (!(pos > HT + 5 && pos < FRAME / 2) && guard < 2 * FRAME) begin
            step(1);
            guard++;
        end
        n0 = fs_times.size();
        vif.en = 1'b0;
        step(50);
        vif.en = 1'b1;
        step(FRAME + HT);
        if (n0 > 0 && fs_times.size() > n0)
            check("frame_period_en_gap", 64'(fs_times[n0] - fs_times[n0 - 1]), 64'(FRAME + 50));
        else
            check("frame_start_after_gap", 64'(fs_times.size()), 64'(n0 + 1));

        step(100);
        rst_n = 1'b0;
        step(1);
        check("midrst_de", {63'd0, vif.de}, 64'd0);
        check("midrst_rgb", {40'd0, vif.red, vif.green, vif.blue}, 64'd0);
        rst_n = 1'b1;
        rel_edge = cyc;
        n0 = fs_times.size();
        step(5);
        if (fs_times.size() > n0)
            check("frame_start_after_rst", 64'(fs_times[n0]), 64'(rel_edge + 1));
        else
            check("frame_start_after_rst_seen", 64'(fs_times.size()), 64'(n0 + 1));

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end else if (r <= 2) begin
                vif.en = 1'b0;
                step($urandom_range(1, 8));
                vif.en = 1'b1;
            end else begin
                vif.pattern_sel = 2'($urandom_range(0, 3));
            end
            step($urandom_range(1, 80));
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
